// File: rtl/pipelined_datapath_if.sv
// -----------------------------------------------------------------------------
// pipelined_datapath_if
// Bundles the micro-op issue handshake, the data-memory port and the
// writeback/flag observation signals of pipelined_datapath.
//
// Handshake semantics: a micro-op (op, rd, rs, imm, use_imm) transfers on a
// rising clock edge where in_valid && in_ready are both 1. The issuer holds the
// micro-op fields stable while in_valid is 1 and in_ready is 0. in_ready never
// depends on in_valid. On the memory side mem_req, mem_we, mem_addr and
// mem_wdata stay stable until a rising edge samples mem_ack=1. mem_rdata is
// taken on that same edge. mem_ack while mem_req=0 has no effect.
//
// Modports:
//   slave  - the datapath: receives micro-ops and memory responses, drives
//            requests, flags and writeback.
//   master - the environment: the decode unit plus the memory arbiter.
// -----------------------------------------------------------------------------
interface pipelined_datapath_if #(
   parameter int WIDTH   = 16,
   parameter int REGBITS = 4
) ();
   logic               in_valid;
   logic               in_ready;
   logic [3:0]         op;
   logic [REGBITS-1:0] rd;
   logic [REGBITS-1:0] rs;
   logic [WIDTH-1:0]   imm;
   logic               use_imm;
   logic               mem_req;
   logic               mem_we;
   logic [WIDTH-1:0]   mem_addr;
   logic [WIDTH-1:0]   mem_wdata;
   logic [WIDTH-1:0]   mem_rdata;
   logic               mem_ack;
   logic [4:0]         flags;
   logic               wb_valid;
   logic [REGBITS-1:0] wb_addr;
   logic [WIDTH-1:0]   wb_data;

   modport slave (
      input  in_valid, op, rd, rs, imm, use_imm, mem_rdata, mem_ack,
      output in_ready, mem_req, mem_we, mem_addr, mem_wdata, flags,
             wb_valid, wb_addr, wb_data
   );

   modport master (
      output in_valid, op, rd, rs, imm, use_imm, mem_rdata, mem_ack,
      input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, flags,
             wb_valid, wb_addr, wb_data
   );
endinterface

// File: rtl/pipelined_datapath.sv
// -----------------------------------------------------------------------------
// pipelined_datapath
// Three-stage datapath (accept/read, execute, writeback) with register file,
// ALU, signed-amount shifter, {C,F,L,N,Z} flag register, EX/WB forwarding and
// a req/ack data-memory port.
//
// Ports:
//   clk    - clock
//   reset  - synchronous, active-low reset
//   dp     - pipelined_datapath_if.slave: micro-op issue (in_valid/in_ready,
//            op, rd, rs, imm, use_imm), memory port (mem_req, mem_we,
//            mem_addr, mem_wdata, mem_rdata, mem_ack), flags and writeback
//            (wb_valid, wb_addr, wb_data).
//
// Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV, 6 CMP, 7 LSH, 8 ASH,
//          9 LOAD, 10 STOR, 11-15 NOP.
// -----------------------------------------------------------------------------
module pipelined_datapath #(
   parameter int WIDTH   = 16,
   parameter int REGBITS = 4
) (
   input logic                  clk,
   input logic                  reset,
   pipelined_datapath_if.slave  dp
);
   localparam int NREGS = 2 ** REGBITS;
   localparam int MSB   = WIDTH - 1;
   localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_MOV  = 4'd5;
   localparam logic [3:0] OP_CMP  = 4'd6;
   localparam logic [3:0] OP_LSH  = 4'd7;
   localparam logic [3:0] OP_ASH  = 4'd8;
   localparam logic [3:0] OP_LOAD = 4'd9;
   localparam logic [3:0] OP_STOR = 4'd10;

   // Architectural and pipeline state
   logic [WIDTH-1:0]   rf_q [NREGS];
   logic               ex_valid_q, ex_valid_d;
   logic [3:0]         ex_op_q;
   logic [REGBITS-1:0] ex_rd_q;
   logic [WIDTH-1:0]   ex_a_q, ex_b_q;
   logic               wb_valid_q, wb_valid_d;
   logic [REGBITS-1:0] wb_addr_q;
   logic [WIDTH-1:0]   wb_data_q, wb_data_d;
   logic [4:0]         flags_q, flags_d;

   // Control
   logic ex_is_mem, ex_done, ex_writes, ex_fwd, in_ready, accept;

   // Execute-stage datapath
   logic [WIDTH:0]   sum, diff;
   logic             shift_neg, shift_big;
   logic [WIDTH-1:0] shift_mag, shl, shr, sar, alu_res;

   // Accept-stage operands
   logic [WIDTH-1:0] opa, src, opb;

   // Any memory op in EX holds issue until its ack has been taken. This also
   // covers the load-use hazard, since a LOAD is a memory op, and it keeps
   // in_ready a function of registered state and reset only.
   assign ex_is_mem = ex_valid_q && (ex_op_q == OP_LOAD || ex_op_q == OP_STOR);
   assign ex_done   = ex_valid_q && (!ex_is_mem || dp.mem_ack);
   assign in_ready  = reset && !ex_is_mem;
   assign accept    = dp.in_valid && in_ready;
   assign ex_fwd    = ex_valid_q && ex_writes && (ex_op_q != OP_LOAD);

   always_comb begin
      sum       = {1'b0, ex_a_q} + {1'b0, ex_b_q};
      diff      = {1'b0, ex_a_q} - {1'b0, ex_b_q};
      // B is a signed shift amount: positive shifts left, negative shifts right.
      shift_neg = ex_b_q[MSB];
      shift_mag = shift_neg ? -ex_b_q : ex_b_q;
      shift_big = (shift_mag >= SHIFT_LIM);
      shl       = ex_a_q << shift_mag;
      shr       = ex_a_q >> shift_mag;
      sar       = $unsigned($signed(ex_a_q) >>> shift_mag);

      alu_res   = '0;
      ex_writes = 1'b0;
      flags_d   = flags_q;
      case (ex_op_q)
         OP_ADD: begin
            alu_res   = sum[MSB:0];
            ex_writes = 1'b1;
            flags_d   = {sum[WIDTH],
                         (ex_a_q[MSB] == ex_b_q[MSB]) && (sum[MSB] != ex_a_q[MSB]),
                         flags_q[2], sum[MSB], (sum[MSB:0] == '0)};
         end
         OP_SUB: begin
            alu_res   = diff[MSB:0];
            ex_writes = 1'b1;
            // diff[WIDTH] is the borrow out of the unsigned subtraction
            flags_d   = {diff[WIDTH],
                         (ex_a_q[MSB] != ex_b_q[MSB]) && (diff[MSB] != ex_a_q[MSB]),
                         flags_q[2], diff[MSB], (diff[MSB:0] == '0)};
         end
         OP_AND: begin alu_res = ex_a_q & ex_b_q; ex_writes = 1'b1; end
         OP_OR:  begin alu_res = ex_a_q | ex_b_q; ex_writes = 1'b1; end
         OP_XOR: begin alu_res = ex_a_q ^ ex_b_q; ex_writes = 1'b1; end
         OP_MOV: begin alu_res = ex_b_q;          ex_writes = 1'b1; end
         OP_CMP: begin
            flags_d = {flags_q[4], flags_q[3], (ex_a_q < ex_b_q),
                       ($signed(ex_a_q) < $signed(ex_b_q)), (ex_a_q == ex_b_q)};
         end
         OP_LSH: begin
            ex_writes = 1'b1;
            if (shift_big)      alu_res = '0;
            else if (shift_neg) alu_res = shr;
            else                alu_res = shl;
         end
         OP_ASH: begin
            ex_writes = 1'b1;
            if (shift_neg)      alu_res = shift_big ? {WIDTH{ex_a_q[MSB]}} : sar;
            else if (shift_big) alu_res = '0;
            else                alu_res = shl;
         end
         OP_LOAD: ex_writes = 1'b1;
         default: ex_writes = 1'b0;
      endcase

      ex_valid_d = accept || (ex_valid_q && !ex_done);
      wb_valid_d = ex_done && ex_writes;
      wb_data_d  = (ex_op_q == OP_LOAD) ? dp.mem_rdata : alu_res;
   end

   // Operand read with forwarding: EX result beats the WB register, which
   // beats the register file (so a same-cycle WB write is seen here too).
   always_comb begin
      opa = rf_q[dp.rd];
      if (wb_valid_q && wb_addr_q == dp.rd) opa = wb_data_q;
      if (ex_fwd && ex_rd_q == dp.rd)       opa = alu_res;
      src = rf_q[dp.rs];
      if (wb_valid_q && wb_addr_q == dp.rs) src = wb_data_q;
      if (ex_fwd && ex_rd_q == dp.rs)       src = alu_res;
      opb = dp.use_imm ? dp.imm : src;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
         ex_valid_q <= 1'b0;
         ex_op_q    <= '0;
         ex_rd_q    <= '0;
         ex_a_q     <= '0;
         ex_b_q     <= '0;
         wb_valid_q <= 1'b0;
         wb_addr_q  <= '0;
         wb_data_q  <= '0;
         flags_q    <= '0;
      end else begin
         if (wb_valid_q) rf_q[wb_addr_q] <= wb_data_q;
         ex_valid_q <= ex_valid_d;
         if (accept) begin
            ex_op_q <= dp.op;
            ex_rd_q <= dp.rd;
            ex_a_q  <= opa;
            ex_b_q  <= opb;
         end
         wb_valid_q <= wb_valid_d;
         if (wb_valid_d) begin
            wb_addr_q <= ex_rd_q;
            wb_data_q <= wb_data_d;
         end
         // flags_d equals flags_q for ops that do not touch flags
         if (ex_valid_q) flags_q <= flags_d;
      end
   end

   // Memory port: address is operand B (R[rs] for register-addressed ops),
   // store data is operand A (R[rd]); both are zero while no request is out.
   assign dp.in_ready  = in_ready;
   assign dp.mem_req   = ex_is_mem;
   assign dp.mem_we    = ex_is_mem && (ex_op_q == OP_STOR);
   assign dp.mem_addr  = ex_is_mem ? ex_b_q : '0;
   assign dp.mem_wdata = ex_is_mem ? ex_a_q : '0;
   assign dp.flags     = flags_q;
   assign dp.wb_valid  = wb_valid_q;
   assign dp.wb_addr   = wb_addr_q;
   assign dp.wb_data   = wb_data_q;
endmodule
